p256_squarer: RTL and testbench
===============================

Name: p256_squarer

Overview:
- Multi-cycle 256-bit integer squarer; the stage directly upstream of the P-256 reducer.
- Squares a 256-bit operand using one LIMB_W x LIMB_W multiplier, iterated over limb pairs.
- Exploits squaring symmetry: each cross product is computed once and doubled.
- Presents the 512-bit product as prod_high/prod_low with a one-cycle done pulse, which drives the reducer's ena/a_high/a_low.

Parameters:
- WIDTH, 256, operand width in bits.
- LIMB_W, 64, limb width in bits. WIDTH must be an integer multiple of LIMB_W. N = WIDTH/LIMB_W.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  request; sampled only when busy=0.
- a  input  WIDTH  operand; sampled on the accepting edge only.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; product valid.
- prod_high  output  WIDTH  upper half of a*a, bits [2*WIDTH-1:WIDTH].
- prod_low  output  WIDTH  lower half of a*a, bits [WIDTH-1:0].

Behaviour:
- Reset: clk is the clock; reset rst_n is asynchronous and active-low.
  - Outputs: busy=0, done=0, prod_high=0, prod_low=0.
  - Internal: state=IDLE, pair counters=0, accumulator=0, captured operand=0.
- States: IDLE, MUL, DONE. busy = (state != IDLE), decoded from the state register.
- IDLE:
  - On an edge with start=1: capture a into the operand register, clear the 2*WIDTH-bit accumulator, set (i,j)=(0,0), go to MUL.
  - start=0: hold.
- MUL: one limb pair per edge, in order i=0..N-1, j=i..N-1. For N=4: (0,0),(0,1),(0,2),(0,3),(1,1),(1,2),(1,3),(2,2),(2,3),(3,3).
  - Term = a_i*a_j (2*LIMB_W bits).
  - If i!=j, the term is doubled, giving 2*LIMB_W+1 bits.
  - The term is shifted left by LIMB_W*(i+j) and added to the accumulator, modulo 2^(2*WIDTH).
  - No overflow can occur: all terms are non-negative and the total is < 2^(2*WIDTH). No carry-out is kept.
  - After the pair (N-1,N-1) is added, go to DONE.
  - MUL lasts N(N+1)/2 edges (10 for the defaults).
- DONE: on one edge, prod_high/prod_low <= accumulator halves, done <= 1, state <= IDLE.
- done timing: high for exactly one cycle; it deasserts on the following edge.
- Latency: start-accept edge = edge 0. done is high in the cycle after edge N(N+1)/2+1, i.e. after edge 11 for the defaults.
- Output hold: prod_high/prod_low change only on the DONE edge and hold until the next completion or reset.
- Busy start: start while busy=1 is ignored, with no queuing. Changes on a after acceptance have no effect.
- Back-to-back: state is IDLE in the done-high cycle, so start in that cycle is accepted. The previous outputs remain valid while the new operation runs.
- Reset mid-operation: aborts immediately with reset values; no done is issued for the aborted operation.

Test Plan:
- a=0, start pulse -> done exactly 11 cycles after the accepting edge; prod_high=0, prod_low=0; busy high for cycles 1-11 after acceptance.
- a=1 -> prod_high=0, prod_low=1.
- a=0xFFFFFFFFFFFFFFFF (limb0 only) -> prod_high=0, prod_low=0x...0000_FFFFFFFFFFFFFFFE_0000000000000001.
- a=2^128 -> prod_high=1, prod_low=0.
- a=2^256-1 -> prod_high=0xFFFF...FFFE, prod_low=1.
- Control scenarios:
  - start re-pulsed mid-MUL with a different operand -> ignored; the result is for the first operand.
  - start asserted in the done cycle -> accepted; second done follows 11 cycles later.
  - rst_n low at MUL cycle 5 -> all outputs 0, no done.
  - 1000 random operands -> match a golden model.

Source files
------------

// File: rtl/p256_squarer.sv
// Multi-cycle WIDTH-bit squarer feeding the P-256 reducer: one LIMB_W x LIMB_W multiply per
// clock over the upper-triangle limb pairs, cross products doubled, 2*WIDTH-bit accumulator.
//
//   state | meaning
//   IDLE  | waiting for start; last product held on prod_high/prod_low
//   MUL   | accumulating one limb pair (i,j), j >= i, per edge
//   DONE  | publishing accumulator halves, pulsing done

module p256_squarer #(
    parameter int WIDTH  = 256,
    parameter int LIMB_W = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] prod_high,
    output logic [WIDTH-1:0] prod_low
);

    localparam int N     = WIDTH / LIMB_W;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int ACC_W = 2 * WIDTH;
    localparam int PW    = 2 * LIMB_W;
    localparam int SH_W  = $clog2(ACC_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0]  op_reg;
    logic [ACC_W-1:0]  acc;
    logic [IDX_W-1:0]  i_idx;
    logic [IDX_W-1:0]  j_idx;

    logic [LIMB_W-1:0] limb_i;
    logic [LIMB_W-1:0] limb_j;
    logic [PW-1:0]     limb_prod;
    logic [PW:0]       term;
    logic [SH_W-1:0]   shamt;
    logic [ACC_W-1:0]  term_aligned;
    logic              last_pair;

    // Datapath for the current pair; off-diagonal terms appear twice in a*a, so double once.
    always_comb begin
        limb_i       = op_reg[int'(i_idx) * LIMB_W +: LIMB_W];
        limb_j       = op_reg[int'(j_idx) * LIMB_W +: LIMB_W];
        limb_prod    = PW'(limb_i) * PW'(limb_j);
        term         = (i_idx == j_idx) ? {1'b0, limb_prod} : {limb_prod, 1'b0};
        shamt        = SH_W'(LIMB_W * (int'(i_idx) + int'(j_idx)));
        term_aligned = ACC_W'(term) << shamt;
        last_pair    = (i_idx == LAST_IDX) && (j_idx == LAST_IDX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = MUL;
            MUL:     if (last_pair) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_reg    <= '0;
            acc       <= '0;
            i_idx     <= '0;
            j_idx     <= '0;
            prod_high <= '0;
            prod_low  <= '0;
            done      <= 1'b0;
        end else begin
            done <= (state == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        op_reg <= a;
                        acc    <= '0;
                        i_idx  <= '0;
                        j_idx  <= '0;
                    end
                end
                MUL: begin
                    acc <= acc + term_aligned;
                    // Walk j = i..N-1, then restart j at the new diagonal.
                    if (j_idx == LAST_IDX) begin
                        if (i_idx != LAST_IDX) begin
                            i_idx <= i_idx + IDX_W'(1);
                            j_idx <= i_idx + IDX_W'(1);
                        end
                    end else begin
                        j_idx <= j_idx + IDX_W'(1);
                    end
                end
                DONE: begin
                    prod_high <= acc[ACC_W-1:WIDTH];
                    prod_low  <= acc[WIDTH-1:0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_p256_squarer.sv
// Self-checking bench for p256_squarer: fixed vectors, control corner cases and random
// operands compared against a plain 512-bit a*a reference.

module tb_p256_squarer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [255:0] a;
    logic         busy;
    logic         done;
    logic [255:0] prod_high;
    logic [255:0] prod_low;

    int checks   = 0;
    int failures = 0;

    logic [255:0] prev_hi;
    logic [255:0] prev_lo;

    typedef struct {
        logic [255:0] op;
        logic [255:0] hi;
        logic [255:0] lo;
    } vec_t;

    vec_t vecs[7];

    always #5 clk = ~clk;

    p256_squarer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a         (a),
        .busy      (busy),
        .done      (done),
        .prod_high (prod_high),
        .prod_low  (prod_low)
    );

    function automatic logic [511:0] golden(input logic [255:0] x);
        logic [511:0] w;
        w = {256'd0, x};
        return w * w;
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Called while clk is low; returns just after the accepting edge.
    task automatic issue(input logic [255:0] op);
        a     = op;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = ~op;
        check("done_after_accept", {255'd0, done}, 256'd0);
    endtask

    task automatic finish_op(input string name, input logic [255:0] exp_hi,
                             input logic [255:0] exp_lo, input bit poke_mid,
                             input logic [255:0] poke_val);
        int lat;
        bit seen;
        bit busy_ok;
        bit hold_ok;
        lat     = -1;
        seen    = 1'b0;
        busy_ok = 1'b1;
        hold_ok = 1'b1;
        for (int cyc = 0; cyc <= 20 && !seen; cyc++) begin
            @(negedge clk);
            if (poke_mid && cyc == 4) begin
                start = 1'b1;
                a     = poke_val;
            end
            if (poke_mid && cyc == 5) start = 1'b0;
            if (done) begin
                seen = 1'b1;
                lat  = cyc;
                if (busy) busy_ok = 1'b0;
            end else begin
                if (!busy) busy_ok = 1'b0;
                if (prod_high !== prev_hi || prod_low !== prev_lo) hold_ok = 1'b0;
            end
        end
        check({name, "_latency"}, 256'(lat), 256'd11);
        check({name, "_busy"}, {255'd0, busy_ok}, 256'd1);
        check({name, "_hold"}, {255'd0, hold_ok}, 256'd1);
        check({name, "_high"}, prod_high, exp_hi);
        check({name, "_low"}, prod_low, exp_lo);
        prev_hi = exp_hi;
        prev_lo = exp_lo;
    endtask

    initial begin
        logic [255:0] op;
        logic [511:0] g;
        bit           saw_done;

        vecs[0] = '{256'd0, 256'd0, 256'd0};
        vecs[1] = '{256'd1, 256'd0, 256'd1};
        vecs[2] = '{{192'd0, 64'hFFFF_FFFF_FFFF_FFFF}, 256'd0,
                    {128'd0, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001}};
        vecs[3] = '{{127'd0, 1'b1, 128'd0}, 256'd1, 256'd0};
        vecs[4] = '{{256{1'b1}}, {{255{1'b1}}, 1'b0}, 256'd1};
        vecs[5] = '{{1'b1, 255'd0}, {2'b01, 254'd0}, 256'd0};
        vecs[6] = '{{191'd0, 1'b1, 64'd1}, 256'd0, {128'd1, 64'd2, 64'd1}};

        rst_n   = 1'b0;
        start   = 1'b0;
        a       = '0;
        prev_hi = '0;
        prev_lo = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", {255'd0, busy}, 256'd0);
        check("reset_done", {255'd0, done}, 256'd0);
        check("reset_high", prod_high, 256'd0);
        check("reset_low", prod_low, 256'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 7; v++) begin
            issue(vecs[v].op);
            finish_op($sformatf("vec%0d", v), vecs[v].hi, vecs[v].lo, 1'b0, 256'd0);
        end

        // start pulsed mid-operation with another operand must be ignored
        op = rand256();
        g  = golden(op);
        issue(op);
        finish_op("busy_start", g[511:256], g[255:0], 1'b1, rand256());

        // start in the done cycle is accepted; the next op is issued with no idle gap
        op = rand256();
        g  = golden(op);
        issue(op);
        finish_op("b2b", g[511:256], g[255:0], 1'b0, 256'd0);

        // reset in the middle of MUL aborts with no done
        issue(rand256());
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", {255'd0, busy}, 256'd0);
        check("midrst_done", {255'd0, done}, 256'd0);
        check("midrst_high", prod_high, 256'd0);
        check("midrst_low", prod_low, 256'd0);
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
        saw_done = 1'b0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        check("midrst_no_done", {255'd0, saw_done}, 256'd0);
        prev_hi = '0;
        prev_lo = '0;

        for (int r = 0; r < 1000; r++) begin
            op = rand256();
            if ($urandom_range(3) == 0) op[63:0] = '1;
            if ($urandom_range(3) == 0) op[255:192] = '1;
            if ($urandom_range(7) == 0) op[191:64] = '0;
            g = golden(op);
            issue(op);
            finish_op("rand", g[511:256], g[255:0], 1'b0, 256'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
